instr_fetch: RTL and testbench
==============================

# instr_fetch

Program-sequencing stage that sits directly upstream of the `pratica2` processor and drives its `ir`, `din` and `run` inputs. It holds a program counter and reads instruction words from an external synchronous ROM. For `MVI` it also fetches the following word as the immediate. It presents each instruction with a one-cycle `run` pulse, then waits for the processor's `done` before fetching the next one.

## Interface
- `ADDR_W`, default 5: ROM address width; the program space is 2^ADDR_W words.
- `DATA_W`, default 16: ROM word width and width of `din`.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin execution from the current `pc`; sampled only in IDLE.
- `done` in 1: processor finished the current instruction; sampled only in WAIT.
- `mem_addr` out ADDR_W: ROM read address.
- `mem_data` in DATA_W: ROM read data, valid the cycle after `mem_addr`.
- `ir` out 9: instruction to the processor, encoded as `III XXX YYY`.
- `din` out DATA_W: immediate for `MVI`.
- `run` out 1: one-cycle issue strobe.
- `pc` out ADDR_W: current program counter.
- `halted` out 1: a HALT opcode has been reached.

## Operation
- Instruction word layout: `mem_data[8:0]` is the IR; upper bits are ignored.
- Opcodes:
  - `000` MV
  - `001` MVI
  - `010` ADD
  - `011` SUB
  - `111` HALT
  - `100`–`110` are issued unchanged; the processor owns their meaning.
- FSM states: IDLE, F_ADDR, F_DATA, I_ADDR, I_DATA, ISSUE, WAIT, HALT.
  - IDLE: `start` → F_ADDR.
  - F_ADDR: `mem_addr = pc` → F_DATA.
  - F_DATA: latch `ir <= mem_data[8:0]`; `pc <= pc+1`. Opcode `111` → HALT (`ir` is still latched). Opcode `001` → I_ADDR. Any other opcode → ISSUE.
  - I_ADDR: `mem_addr = pc` → I_DATA.
  - I_DATA: `din <= mem_data`; `pc <= pc+1` → ISSUE.
  - ISSUE: `run = 1` for exactly this cycle → WAIT.
  - WAIT: `done` → F_ADDR; otherwise stay.
  - HALT: `halted = 1`; absorbing until `reset`.
- `mem_addr` is registered from `pc`; it equals `pc` in every state.
- `ir` and `din` hold stable from ISSUE through the end of WAIT.
- `din` keeps its last immediate across non-MVI instructions.
- `pc` wraps from 2^ADDR_W−1 to 0 with no flag. An MVI at the last address takes its immediate from address 0.
- `start` outside IDLE is ignored. `done` outside WAIT is ignored. A `done` asserted in the ISSUE cycle is not sampled.
- Reset values: state IDLE; `pc`, `mem_addr`, `ir`, `din` = 0; `run` and `halted` = 0.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous), including `run` in ISSUE. No instruction is re-issued after release.

## Timing
- `start` sampled high at edge k:
  - F_ADDR during cycle k+1, F_DATA during k+2.
  - Non-MVI: `run` high during cycle k+3.
  - MVI: I_ADDR k+3, I_DATA k+4, `run` high during k+5.
- `done` sampled high at edge m: F_ADDR during m+1, next `run` at m+3 (non-MVI) or m+5 (MVI).
- Minimum issue interval: 4 cycles (non-MVI with `done` in the first WAIT cycle); 6 cycles for MVI.
- HALT: `halted` is high from the cycle after the F_DATA that read `111`.

## Structure
- Shared package `pratica2_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_HALT`;
  - the fetch-state enum `fetch_state_t`;
  - the IR field slice positions.
- The processor uses the same opcode constants from this package.
- Single module; no sub-module. The ROM stays external so programs can be swapped per bench.

## Test plan
- ROM {0:`0x040`, 1:`0x0002`, 2:`0x008`, 3:`0x1C0`}, `start` pulse, `done` one cycle after each `run`:
  - `run`#1 shows `ir=0x040`, `din=2`;
  - `run`#2 shows `ir=0x008`, `din=2`;
  - then `halted=1` with `pc=4` and `run` never pulses again.
- ROM {0:`0x089`, 1:`0x0D0`}: `run` at k+3 with `ir=0x089`. `done` held low 10 cycles keeps `ir` stable and `run` low. `done` → `ir=0x0D0` at m+3.
- ADDR_W=2, ROM {3:`0x040`, 0:`0x1234`}, `pc` preloaded to 3 by running three non-MVI instructions: `run` with `din=0x1234`, `pc` wrapped to 1.
- `reset` asserted during the ISSUE cycle: `run`, `pc`, `ir` drop to 0 the same cycle. After release, nothing happens until `start`.
- `start` held high continuously and spurious `done` outside WAIT: exactly one `run` per `done`-in-WAIT; no extra fetches.

Source files
------------

// File: rtl/pratica2_pkg.sv
// Shared definitions for the pratica2 processor and its instruction fetch stage:
// opcode constants, IR field positions and the fetch-state encoding.
package pratica2_pkg;

    localparam int IR_W = 9;

    // IR layout is III XXX YYY
    localparam int IR_OP_MSB = 8;
    localparam int IR_OP_LSB = 6;
    localparam int IR_X_MSB  = 5;
    localparam int IR_X_LSB  = 3;
    localparam int IR_Y_MSB  = 2;
    localparam int IR_Y_LSB  = 0;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_F_ADDR,
        FS_F_DATA,
        FS_I_ADDR,
        FS_I_DATA,
        FS_ISSUE,
        FS_WAIT,
        FS_HALT
    } fetch_state_t;

    function automatic logic [2:0] ir_opcode(input logic [IR_W-1:0] ir_word);
        return ir_word[IR_OP_MSB:IR_OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Program sequencer feeding the pratica2 processor: fetches instruction words
// (plus the immediate for MVI) from an external synchronous ROM and issues them with a run strobe.
module instr_fetch
    import pratica2_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [IR_W-1:0]   ir,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] din_q, din_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        din_d   = din_q;
        unique case (state_q)
            FS_IDLE: begin
                if (start) begin
                    state_d = FS_F_ADDR;
                end
            end
            FS_F_ADDR: state_d = FS_F_DATA;
            FS_F_DATA: begin
                ir_d = mem_data[IR_W-1:0];
                pc_d = pc_q + ADDR_W'(1);
                if (ir_opcode(mem_data[IR_W-1:0]) == OP_HALT) begin
                    state_d = FS_HALT;
                end else if (ir_opcode(mem_data[IR_W-1:0]) == OP_MVI) begin
                    state_d = FS_I_ADDR;
                end else begin
                    state_d = FS_ISSUE;
                end
            end
            FS_I_ADDR: state_d = FS_I_DATA;
            FS_I_DATA: begin
                din_d   = mem_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = FS_ISSUE;
            end
            FS_ISSUE: state_d = FS_WAIT;
            FS_WAIT: begin
                if (done) begin
                    state_d = FS_F_ADDR;
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_IDLE;
        endcase
    end

    // mem_addr tracks the next pc so the ROM read is already in flight in F_ADDR/I_ADDR
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FS_IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= pc_d;
            ir_q       <= ir_d;
            din_q      <= din_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign din      = din_q;
    assign run      = (state_q == FS_ISSUE);
    assign halted   = (state_q == FS_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed programs plus random programs
// compared against a program-walk reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default-size instance
    logic        rst, start, done;
    logic [4:0]  mem_addr, pc;
    logic [15:0] mem_data, din;
    logic [8:0]  ir;
    logic        run, halted;
    logic [15:0] rom [32];

    // ADDR_W=2 instance for wrap-around
    logic        rst2, start2, done2;
    logic [1:0]  mem_addr2, pc2;
    logic [15:0] mem_data2, din2;
    logic [8:0]  ir2;
    logic        run2, halted2;
    logic [15:0] rom2 [4];

    instr_fetch #(.ADDR_W(5), .DATA_W(16)) dut (
        .clock(clk), .reset(rst), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .ir(ir), .din(din), .run(run), .pc(pc), .halted(halted)
    );

    instr_fetch #(.ADDR_W(2), .DATA_W(16)) dut2 (
        .clock(clk), .reset(rst2), .start(start2), .done(done2),
        .mem_addr(mem_addr2), .mem_data(mem_data2),
        .ir(ir2), .din(din2), .run(run2), .pc(pc2), .halted(halted2)
    );

    always @(posedge clk) begin
        mem_data  <= rom[mem_addr];
        mem_data2 <= rom2[mem_addr2];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0]  ir;
        logic [15:0] din;
        logic [4:0]  pc;
        int          lat;
        bit          halt;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Pulse start or done, then count cycles until run is seen (bounded).
    task automatic go(input bit use_start, output int lat);
        if (use_start) start = 1'b1;
        else done = 1'b1;
        step();
        start = 1'b0;
        done = 1'b0;
        lat = 1;
        while (!run && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Reference: walk the program by the ISA rules and list what each issue must show.
    task automatic build_model();
        logic [4:0]  mpc;
        logic [15:0] mdin;
        logic [15:0] w;
        exp_t        e;
        exp_q.delete();
        mpc = 0;
        mdin = 0;
        for (int n = 0; n < 40; n++) begin
            w = rom[mpc];
            mpc = mpc + 1;
            e.ir = w[8:0];
            e.halt = (w[8:6] == 3'd7);
            e.lat = 3;
            if (w[8:6] == 3'd1) begin
                mdin = rom[mpc];
                mpc = mpc + 1;
                e.lat = 5;
            end
            e.din = mdin;
            e.pc = mpc;
            exp_q.push_back(e);
            if (e.halt) break;
        end
    endtask

    initial begin
        int   lat;
        int   extra;
        int   cd;
        int   post;
        bit   waiting, just_ran, exp_run, exp_halted;
        exp_t e;
        logic [15:0] w;

        rst = 1'b1; start = 1'b0; done = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; done2 = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0;
        for (int i = 0; i < 4; i++) rom2[i] = 16'h0;

        // Program 1: MVI, MV, HALT
        rom[0] = 16'h0040; rom[1] = 16'h0002; rom[2] = 16'h0008; rom[3] = 16'h01C0;
        do_reset();
        chk("reset_pc", 32'(pc), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_ir", 32'(ir), 0);
        chk("reset_din", 32'(din), 0);
        chk("reset_run_halted", {30'd0, run, halted}, 0);

        go(1'b1, lat);
        chk("p1_mvi_latency", lat, 5);
        chk("p1_mvi_ir", 32'(ir), 32'h040);
        chk("p1_mvi_din", 32'(din), 2);
        chk("p1_mvi_pc", 32'(pc), 2);
        step();
        chk("p1_run_one_cycle", 32'(run), 0);
        go(1'b0, lat);
        chk("p1_mv_latency", lat, 3);
        chk("p1_mv_ir", 32'(ir), 32'h008);
        chk("p1_mv_din_kept", 32'(din), 2);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("p1_not_halted_early", 32'(halted), 0);
        step();
        chk("p1_halted", 32'(halted), 1);
        chk("p1_halt_pc", 32'(pc), 4);
        chk("p1_halt_ir", 32'(ir), 32'h1C0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            done = i[0];
            start = 1'b1;
            step();
            if (run) extra++;
        end
        done = 1'b0; start = 1'b0;
        chk("p1_no_run_after_halt", extra, 0);
        chk("p1_halt_absorbing", 32'(halted), 1);

        // Program 2: ADD, SUB with a long stall
        for (int i = 0; i < 32; i++) rom[i] = 16'h0;
        rom[0] = 16'h0089; rom[1] = 16'h00D0;
        do_reset();
        go(1'b1, lat);
        chk("p2_add_latency", lat, 3);
        chk("p2_add_ir", 32'(ir), 32'h089);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("p2_stall_hold", {22'd0, run, ir}, {22'd0, 1'b0, 9'h089});
        end
        go(1'b0, lat);
        chk("p2_sub_latency", lat, 3);
        chk("p2_sub_ir", 32'(ir), 32'h0D0);
        chk("p2_sub_pc", 32'(pc), 2);

        // Asynchronous reset during ISSUE
        do_reset();
        go(1'b1, lat);
        chk("rst_issue_reached", 32'(run), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {run, halted, 5'(pc), 5'(mem_addr), ir, din},
            {1'b0, 1'b0, 5'd0, 5'd0, 9'd0, 16'd0});
        #2;
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (run || pc != 5'd0) extra++;
        end
        chk("rst_idle_after_release", extra, 0);
        go(1'b1, lat);
        chk("rst_restart_latency", lat, 3);
        chk("rst_restart_ir", 32'(ir), 32'h089);

        // ADDR_W=2 wrap: MVI at last address takes immediate from address 0
        rom2[0] = 16'h1234; rom2[1] = 16'h0089; rom2[2] = 16'h00D0; rom2[3] = 16'h0040;
        step();
        rst2 = 1'b0;
        step();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        lat = 1;
        while (!run2 && lat < 20) begin step(); lat++; end
        chk("wrap_first_ir", 32'(ir2), 32'h034);
        for (int n = 1; n < 4; n++) begin
            step();
            done2 = 1'b1;
            step();
            done2 = 1'b0;
            lat = 1;
            while (!run2 && lat < 20) begin step(); lat++; end
        end
        chk("wrap_mvi_latency", lat, 5);
        chk("wrap_mvi_ir", 32'(ir2), 32'h040);
        chk("wrap_mvi_din", 32'(din2), 32'h1234);
        chk("wrap_pc", 32'(pc2), 1);
        chk("wrap_not_halted", 32'(halted2), 0);

        // Random programs, start held high, random done every cycle
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 32; i++) begin
                w = 16'($urandom);
                if (w[8:6] == 3'd7 && $urandom_range(0, 4) != 0) w[8:6] = 3'($urandom_range(0, 6));
                rom[i] = w;
            end
            build_model();
            do_reset();
            start = 1'b1;
            cd = exp_q[0].lat;
            waiting = 1'b0;
            exp_halted = 1'b0;
            post = 0;
            for (int c = 0; c < 400; c++) begin
                step();
                exp_run = 1'b0;
                just_ran = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        e = exp_q.pop_front();
                        if (e.halt) exp_halted = 1'b1;
                        else begin
                            exp_run = 1'b1;
                            just_ran = 1'b1;
                        end
                        chk("rand_ir", 32'(ir), 32'(e.ir));
                        chk("rand_pc", 32'(pc), 32'(e.pc));
                        chk("rand_din", 32'(din), 32'(e.din));
                    end
                end
                chk("rand_run_halted", {30'd0, run, halted}, {30'd0, exp_run, exp_halted});
                done = ($urandom_range(0, 2) == 0);
                if (waiting && done && !just_ran) begin
                    waiting = 1'b0;
                    if (exp_q.size() > 0) cd = exp_q[0].lat;
                end
                if (just_ran) waiting = 1'b1;
                if (exp_halted) post++;
                if (post >= 10) break;
                if (exp_q.size() == 0 && cd == 0 && !exp_halted && !waiting) break;
            end
            start = 1'b0;
            done = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
